demux1to16_deser: RTL and testbench
===================================

# demux1to16_deser

Serial-to-parallel demultiplexer, the receive end of the 16:1 mux serialiser. The mux presents `w[s]` on its output as `s` steps 0..15; this block takes that bit stream one bit per valid cycle and steers each bit into slot `w[s]`. A 4-bit slot counter drives a one-hot write-enable decoder. When a full 16-bit word is assembled, it is presented in parallel with a one-cycle valid strobe.

## Interface
Parameters:
- `WORD_W`, default 16: word width; a power of two, 2..16.
- `SEL_W`, default 4: slot index width; always $clog2(WORD_W).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `din` input 1: serial data bit, the mux output `f`.
- `din_valid` input 1: `din` is sampled this cycle.
- `clr` input 1: synchronous frame realign; discards the partial word and returns the slot to 0.
- `s` output `SEL_W`: index of the slot the next valid bit will fill; mirrors the mux select.
- `w` output [0:`WORD_W`-1]: last complete word; `w[0]` is slot 0, the MSB as written.
- `word_valid` output 1: one-cycle pulse when `w` is updated.
- `parity_err` output 1: parity check result, qualified by `word_valid`.

## Operation
- Reset values: `s`=0, `w`=0, `word_valid`=0, `parity_err`=0; shadow register=0; state=COLLECT.
- State machine states:
  - COLLECT: receiving the data bits.
  - PARITY: only exists with the configuration macro.
- COLLECT, `din_valid`=1 and `s`<`WORD_W`-1:
  - shadow[`s`] <= `din`.
  - `s` <= `s`+1.
- COLLECT, `din_valid`=1 and `s`=`WORD_W`-1, macro absent:
  - `w` <= {shadow[0:`WORD_W`-2], `din`}.
  - `word_valid` <= 1.
  - `s` wraps to 0.
  - The shadow register is not cleared; every slot is overwritten before its next use.
- COLLECT, same condition, macro present:
  - shadow[`WORD_W`-1] <= `din`.
  - Go to PARITY; `s` holds at `WORD_W`-1.
- PARITY, `din_valid`=1:
  - `w` <= shadow.
  - `parity_err` <= (^shadow) ^ `din`; the scheme is even parity.
  - `word_valid` <= 1.
  - `s` <= 0; go to COLLECT.
- `din_valid`=0: nothing changes; gaps of any length are allowed between bits.
- `clr`=1:
  - `s` <= 0, state <= COLLECT; `w` and `parity_err` keep their values; `word_valid` <= 0.
  - `clr` wins over a simultaneous `din_valid`; that bit is discarded.
- `parity_err` holds its value between words.

## Timing
- Each bit is written to the shadow register on the edge where `din_valid`=1.
- `w` and `word_valid` change on the same edge that samples the final bit: the last data bit without the macro, the parity bit with it.
- `word_valid` is high for exactly one cycle, then low unless the next word completes. Back-to-back words need at least `WORD_W` cycles (`WORD_W`+1 with parity).
- `s` is registered and updates on the sampling edge, so an upstream mux can be driven directly from `s`.
- `rst` asserted mid-word clears everything asynchronously; no partial word is emitted.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `DEMUX_PARITY_EN`.
- Defined:
  - The PARITY state exists; each word occupies `WORD_W`+1 bits, the last being even parity over the data bits.
  - `parity_err` is registered as described in Operation.
- Undefined:
  - No PARITY state; each word occupies `WORD_W` bits.
  - `parity_err` is tied to 0; the port list is unchanged.

## Structure
- Package `demux_pkg`:
  - constants `WORD_W_DEF`=16 and `SEL_W_DEF`=4;
  - state enum `demux_state_t` {COLLECT, PARITY}.
- Sub-module `dec4to16`: combinational decoder from `s` plus an enable input to a one-hot `WORD_W`-bit shadow write-enable.
- Top level holds the counter, FSM, shadow register and output registers.

## Test plan
- Reset, then drive the bits of 16'b1010_1100_1101_0001 MSB-first, one per cycle, with `din_valid`=1 → one `word_valid` pulse, `w`=16'b1010_1100_1101_0001, `s` back to 0.
- Same word with 3-cycle `din_valid` gaps between bits → identical `w`; `s` steps 0..15 and holds during gaps.
- Send 7 bits, pulse `clr` together with a valid bit, then send a full word 16'hFFFF → `w`=16'hFFFF; no pulse for the partial word; the bit coinciding with `clr` is dropped.
- Assert `rst` at `s`=9 mid-word → all outputs 0 at once; the next full word 16'h00F0 lands correctly.
- With `DEMUX_PARITY_EN`: send 16'b1010_1100_1101_0001 then parity bit 0 → `parity_err`=0; repeat with parity bit 1 → `parity_err`=1. `word_valid` pulses only after the 17th bit in both cases.
- Two back-to-back words 16'hA5A5 then 16'h5A5A with no gap → two `word_valid` pulses 16 cycles apart with the correct values.

Source files
------------

// File: rtl/demux1to16_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and state type for the 1:16 deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int SEL_W_DEF  = 4;

    // PARITY is only reachable when the parity feature is built in.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } demux_state_t;

endpackage
`default_nettype wire

// File: rtl/demux1to16_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : demux1to16_deser_if
// Description : Serial-in / parallel-out bundle of the 1:16 deserialiser.
//               master = bit-stream source, slave = deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux1to16_deser_if
    import demux_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int SEL_W  = $clog2(WORD_W)
);

    logic                din;
    logic                din_valid;
    logic                clr;
    logic [SEL_W-1:0]    s;
    logic [0:WORD_W-1]   w;
    logic                word_valid;
    logic                parity_err;

    modport master (
        output din, din_valid, clr,
        input  s, w, word_valid, parity_err
    );

    modport slave (
        input  din, din_valid, clr,
        output s, w, word_valid, parity_err
    );

endinterface
`default_nettype wire

// File: rtl/demux1to16_deser_dec4to16.sv
`default_nettype none
// ============================================================================
// Module      : dec4to16
// Description : Slot index to one-hot shadow write-enable decoder.
//               we[i] is high when en is high and sel == i.
// Revision    : 1.0 - initial release
// ============================================================================
module dec4to16
    import demux_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic [0:WORD_W-1] we
);

    // One comparator per slot; slot 0 is the first bit of the word.
    generate
        for (genvar i = 0; i < WORD_W; i++) begin : g_dec
            assign we[i] = en && (sel == SEL_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/demux1to16_deser.sv
`default_nettype none
// ============================================================================
// Module      : demux1to16_deser
// Description : Serial-to-parallel demultiplexer. Steers one bit per valid
//               cycle into slot s of a shadow register and presents the
//               completed word on w with a one-cycle word_valid strobe.
//               Optional feature macro: DEMUX_PARITY_EN (adds a trailing even
//               parity bit per word and a registered parity_err flag).
// Revision    : 1.0 - initial release
// ============================================================================
module demux1to16_deser
    import demux_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    demux1to16_deser_if.slave  bus
);

    localparam logic [SEL_W-1:0] C_LAST_SLOT = SEL_W'(WORD_W - 1);

    demux_state_t       r_state;
    demux_state_t       w_state_nxt;
    logic [SEL_W-1:0]   r_s;
    logic [SEL_W-1:0]   w_s_nxt;
    logic [0:WORD_W-1]  r_shadow;
    logic [0:WORD_W-1]  r_w;
    logic [0:WORD_W-1]  w_w_nxt;
    logic [0:WORD_W-1]  w_we;
    logic               r_word_valid;
    logic               w_word_valid_nxt;
    logic               w_shadow_en;
    logic               w_last;
`ifdef DEMUX_PARITY_EN
    logic               r_parity_err;
    logic               w_parity_err_nxt;
`else
    logic [0:WORD_W-1]  w_word_cat;
`endif

    assign w_last = (r_s == C_LAST_SLOT);

    dec4to16 #(
        .WORD_W (WORD_W),
        .SEL_W  (SEL_W)
    ) u_dec (
        .sel (r_s),
        .en  (w_shadow_en),
        .we  (w_we)
    );

`ifndef DEMUX_PARITY_EN
    // Completed word: stored slots plus the bit arriving on this edge.
    always_comb begin
        w_word_cat             = r_shadow;
        w_word_cat[WORD_W-1]   = bus.din;
    end
`endif

    // Next-state and output decode; clr overrides any simultaneous bit.
    always_comb begin
        w_state_nxt      = r_state;
        w_s_nxt          = r_s;
        w_w_nxt          = r_w;
        w_word_valid_nxt = 1'b0;
        w_shadow_en      = 1'b0;
`ifdef DEMUX_PARITY_EN
        w_parity_err_nxt = r_parity_err;
`endif
        if (bus.clr) begin
            w_s_nxt     = '0;
            w_state_nxt = COLLECT;
        end else if (bus.din_valid) begin
            case (r_state)
                COLLECT: begin
                    w_shadow_en = 1'b1;
                    if (!w_last) begin
                        w_s_nxt = r_s + SEL_W'(1);
                    end else begin
`ifdef DEMUX_PARITY_EN
                        // Hold s at the last slot while the parity bit is awaited.
                        w_state_nxt = PARITY;
`else
                        w_w_nxt          = w_word_cat;
                        w_word_valid_nxt = 1'b1;
                        w_s_nxt          = '0;
`endif
                    end
                end
`ifdef DEMUX_PARITY_EN
                PARITY: begin
                    w_w_nxt          = r_shadow;
                    w_parity_err_nxt = (^r_shadow) ^ bus.din;
                    w_word_valid_nxt = 1'b1;
                    w_s_nxt          = '0;
                    w_state_nxt      = COLLECT;
                end
`endif
                default: begin
                    w_state_nxt = COLLECT;
                end
            endcase
        end
    end

    // State, slot counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= COLLECT;
            r_s          <= '0;
            r_w          <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_s          <= w_s_nxt;
            r_w          <= w_w_nxt;
            r_word_valid <= w_word_valid_nxt;
        end
    end

    // Shadow register: each slot loads din when its decoded enable is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else begin
            for (int i = 0; i < WORD_W; i++) begin
                if (w_we[i]) begin
                    r_shadow[i] <= bus.din;
                end
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    // Parity flag holds between words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_err_nxt;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.s          = r_s;
    assign bus.w          = r_w;
    assign bus.word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: tb/tb_demux1to16_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux1to16_deser
// Description : Self-checking bench for demux1to16_deser. A bit-queue model
//               predicts s, w, word_valid and parity_err every cycle.
//               Honours DEMUX_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1to16_deser;

`ifdef DEMUX_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic clk = 1'b0;
    logic rst;

    demux1to16_deser_if #(.WORD_W(16), .SEL_W(4)) bus ();

    demux1to16_deser #(.WORD_W(16), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          cyc        = 0;
    int          last_pulse = -1;
    int          pulse_cnt  = 0;
    bit          q[$];
    logic [15:0] exp_w;
    logic        exp_valid;
    logic        exp_perr;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_w     = '0;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] obs_w;
        int          exp_s;
        obs_w = bus.w;
        exp_s = (q.size() > 15) ? 15 : q.size();
        check_value({tag, "_s"},    32'(bus.s),          32'(exp_s));
        check_value({tag, "_w"},    32'(obs_w),          32'(exp_w));
        check_value({tag, "_wv"},   32'(bus.word_valid), 32'(exp_valid));
        check_value({tag, "_perr"}, 32'(bus.parity_err), 32'(exp_perr));
    endtask

    // One clock: apply inputs, advance the model on the same edge, compare.
    task automatic step(input logic d, input logic v, input logic c);
        bus.din       = d;
        bus.din_valid = v;
        bus.clr       = c;
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
        if (c) begin
            q.delete();
        end else if (v) begin
            q.push_back(d);
            if (q.size() == NB) begin
                for (int i = 0; i < 16; i++) exp_w[15-i] = q[i];
`ifdef DEMUX_PARITY_EN
                exp_perr = (^exp_w) ^ q[16];
`endif
                exp_valid = 1'b1;
                q.delete();
            end
        end
        check_outputs("cyc");
        if (bus.word_valid) begin
            pulse_cnt++;
            last_pulse = cyc;
        end
    endtask

    // Sends a word MSB first with 'gap' idle cycles after each bit; in the
    // parity build a trailing parity bit (even parity, optionally flipped).
    task automatic send_word(input logic [15:0] word, input int gap, input bit flip);
        for (int i = 0; i < 16; i++) begin
            step(word[15-i], 1'b1, 1'b0);
            for (int g = 0; g < gap; g++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
`ifdef DEMUX_PARITY_EN
        step((^word) ^ flip, 1'b1, 1'b0);
        for (int g = 0; g < gap; g++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
`else
        if (flip) step(1'b0, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        int first_pulse;
        logic [15:0] tmp_w;

        bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Directed word, back-to-back bits
        pulse_cnt = 0;
        send_word(16'b1010_1100_1101_0001, 0, 1'b0);
        tmp_w = bus.w;
        check_value("t1_w", 32'(tmp_w), 32'h0000_ACD1);
        check_value("t1_pulses", 32'(pulse_cnt), 32'd1);
        check_value("t1_s", 32'(bus.s), 32'd0);

        // Same word with 3-cycle gaps
        pulse_cnt = 0;
        send_word(16'b1010_1100_1101_0001, 3, 1'b0);
        tmp_w = bus.w;
        check_value("t2_w", 32'(tmp_w), 32'h0000_ACD1);
        check_value("t2_pulses", 32'(pulse_cnt), 32'd1);

        // Partial word, clr with a coincident valid bit, then a full word
        pulse_cnt = 0;
        for (int i = 0; i < 7; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_value("t3_s_after_clr", 32'(bus.s), 32'd0);
        send_word(16'hFFFF, 0, 1'b0);
        tmp_w = bus.w;
        check_value("t3_w", 32'(tmp_w), 32'h0000_FFFF);
        check_value("t3_pulses", 32'(pulse_cnt), 32'd1);

        // Asynchronous reset mid-word at s=9
        for (int i = 0; i < 9; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        check_value("t4_s_pre", 32'(bus.s), 32'd9);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("t4_async");
        #2 rst = 1'b0;
        pulse_cnt = 0;
        send_word(16'h00F0, 0, 1'b0);
        tmp_w = bus.w;
        check_value("t4_w", 32'(tmp_w), 32'h0000_00F0);
        check_value("t4_pulses", 32'(pulse_cnt), 32'd1);

`ifdef DEMUX_PARITY_EN
        // Parity good then parity bad
        pulse_cnt = 0;
        send_word(16'b1010_1100_1101_0001, 0, 1'b0);
        check_value("t5_perr0", 32'(bus.parity_err), 32'd0);
        send_word(16'b1010_1100_1101_0001, 0, 1'b1);
        check_value("t5_perr1", 32'(bus.parity_err), 32'd1);
        check_value("t5_pulses", 32'(pulse_cnt), 32'd2);
        step(1'b0, 1'b0, 1'b0);
        check_value("t5_perr_hold", 32'(bus.parity_err), 32'd1);
`endif

        // Two words back to back
        send_word(16'hA5A5, 0, 1'b0);
        first_pulse = last_pulse;
        tmp_w = bus.w;
        check_value("t6_w0", 32'(tmp_w), 32'h0000_A5A5);
        send_word(16'h5A5A, 0, 1'b0);
        tmp_w = bus.w;
        check_value("t6_w1", 32'(tmp_w), 32'h0000_5A5A);
        check_value("t6_spacing", 32'(last_pulse - first_pulse), 32'(NB));

        // Random traffic with gaps and occasional realign
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
